// File: rtl/sync_gray_ptr_if.sv
// Bundle of the Gray-pointer synchroniser's data signals: the source pointer and error clear
// going in, the synchronised pointer, its binary form and the status flags coming out.
interface sync_gray_ptr_if #(
    parameter int ADDRSIZE = 4
);
    logic [ADDRSIZE:0] wptr;
    logic              err_clr;
    logic [ADDRSIZE:0] rq_wptr;
    logic [ADDRSIZE:0] rq_wptr_bin;
    logic              rq_wptr_vld;
    logic              rq_wptr_chg;
    logic              sync_err;

    modport master (
        output wptr,
        output err_clr,
        input  rq_wptr,
        input  rq_wptr_bin,
        input  rq_wptr_vld,
        input  rq_wptr_chg,
        input  sync_err
    );

    modport slave (
        input  wptr,
        input  err_clr,
        output rq_wptr,
        output rq_wptr_bin,
        output rq_wptr_vld,
        output rq_wptr_chg,
        output sync_err
    );
endinterface

// File: rtl/sync_gray_ptr.sv
// N-stage synchroniser for a Gray-coded FIFO write pointer entering the rclk domain.
// Define SYNC_ERR_CHK_EN to build the sticky Gray-coherency checker driving sync_err.
module sync_gray_ptr #(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           rclk,
    input  logic           rrst_n,
    sync_gray_ptr_if.slave bus
);
    localparam int            W       = ADDRSIZE + 1;
    localparam int            CW      = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SYNC_STAGES);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("sync_gray_ptr: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    logic [SYNC_STAGES-1:0][W-1:0] r_stage;
    logic [W-1:0]                  r_prev;
    logic                          r_prev_vld;
    logic [CW-1:0]                 r_cnt;
    logic [W-1:0]                  w_rq;
    logic [W-1:0]                  w_bin;
    logic                          w_vld;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_stage    <= '0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_stage[0] <= bus.wptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            r_prev     <= w_rq;
            r_prev_vld <= w_vld;
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_rq  = r_stage[SYNC_STAGES-1];
    assign w_vld = (r_cnt == CNT_MAX);

    always_comb begin
        w_bin      = '0;
        w_bin[W-1] = w_rq[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            w_bin[i] = w_bin[i+1] ^ w_rq[i];
        end
    end

    // prev only holds a real post-reset sample once vld was already high on the previous
    // cycle, so the first qualified value never produces a change pulse or a checker hit.
    logic w_cmp_en;
    assign w_cmp_en = w_vld & r_prev_vld;

    assign bus.rq_wptr     = w_rq;
    assign bus.rq_wptr_bin = w_bin;
    assign bus.rq_wptr_vld = w_vld;
    assign bus.rq_wptr_chg = w_cmp_en & (w_rq != r_prev);

`ifdef SYNC_ERR_CHK_EN
    logic r_sync_err;
    logic w_viol;

    assign w_viol = w_cmp_en & ($countones(w_rq ^ r_prev) > 1);

    // A new violation takes priority over a simultaneous clear.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= w_viol | (r_sync_err & ~bus.err_clr);
        end
    end

    assign bus.sync_err = r_sync_err;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = bus.err_clr;
    assign bus.sync_err     = 1'b0;
`endif
endmodule
